etapa_wb_banco_registros: RTL and testbench

Writeback-end consumer of the MEM/WB pipeline register outputs. It selects the writeback value (memory data or ALU result) and commits it into a 32-entry register file. It serves the ID stage through two combinational read ports with same-cycle write bypass, and keeps a committed-write counter for debug and performance.

---
 rtl/etapa_wb_banco_registros.sv | 80 ++++++++
 tb/tb_etapa_wb_banco_registros.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_wb_banco_registros.sv
// Writeback stage: selects the writeback value and commits it into a 32x register file.
// Two combinational read ports with write-first bypass, plus a committed-write counter.
module etapa_wb_banco_registros #(
    parameter int ANCHO_DATOS    = 32,
    parameter int ANCHO_CONTADOR = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_escribir_WB,
    input  logic                      mem_a_reg_WB,
    input  logic [ANCHO_DATOS-1:0]    dato_memoria_WB,
    input  logic [ANCHO_DATOS-1:0]    resultado_alu_WB,
    input  logic [4:0]                registro_destino_WB,
    input  logic [4:0]                reg_lectura1,
    input  logic [4:0]                reg_lectura2,
    output logic [ANCHO_DATOS-1:0]    dato_lectura1,
    output logic [ANCHO_DATOS-1:0]    dato_lectura2,
    output logic [ANCHO_DATOS-1:0]    dato_escritura_WB,
    output logic                      escritura_valida_WB,
    output logic [ANCHO_CONTADOR-1:0] contador_escrituras
);

    logic [ANCHO_DATOS-1:0]    regs_q [32];
    logic [ANCHO_CONTADOR-1:0] cnt_q;
    logic [ANCHO_CONTADOR-1:0] cnt_d;

    assign dato_escritura_WB   = mem_a_reg_WB ? dato_memoria_WB
                                              : resultado_alu_WB;
    assign escritura_valida_WB = reg_escribir_WB &&
                                 (registro_destino_WB != 5'd0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (escritura_valida_WB) begin
            regs_q[registro_destino_WB] <= dato_escritura_WB;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (escritura_valida_WB) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign contador_escrituras = cnt_q;

    always_comb begin
        dato_lectura1 = regs_q[reg_lectura1];
        if (escritura_valida_WB && (reg_lectura1 == registro_destino_WB)) begin
            dato_lectura1 = dato_escritura_WB;
        end
        if (reg_lectura1 == 5'd0) begin
            dato_lectura1 = '0;
        end
    end

    always_comb begin
        dato_lectura2 = regs_q[reg_lectura2];
        if (escritura_valida_WB && (reg_lectura2 == registro_destino_WB)) begin
            dato_lectura2 = dato_escritura_WB;
        end
        if (reg_lectura2 == 5'd0) begin
            dato_lectura2 = '0;
        end
    end

endmodule

// File: tb/tb_etapa_wb_banco_registros.sv
// Bench for etapa_wb_banco_registros built with a 4-bit counter so wrap is reachable.
// Reference model is an array of registers plus an integer write count.
module tb_etapa_wb_banco_registros;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          m2r;
    logic [W-1:0]  mem_d;
    logic [W-1:0]  alu_d;
    logic [4:0]    dest;
    logic [4:0]    r1;
    logic [4:0]    r2;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic [W-1:0]  wb;
    logic          valid;
    logic [CW-1:0] cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  mregs [32];
    int            mcount;

    etapa_wb_banco_registros #(
        .ANCHO_DATOS(W),
        .ANCHO_CONTADOR(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reg_escribir_WB(en),
        .mem_a_reg_WB(m2r),
        .dato_memoria_WB(mem_d),
        .resultado_alu_WB(alu_d),
        .registro_destino_WB(dest),
        .reg_lectura1(r1),
        .reg_lectura2(r2),
        .dato_lectura1(rd1),
        .dato_lectura2(rd2),
        .dato_escritura_WB(wb),
        .escritura_valida_WB(valid),
        .contador_escrituras(cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(en));
        end
    end

    function automatic logic [W-1:0] m_wb();
        return m2r ? mem_d : alu_d;
    endfunction

    function automatic logic m_valid();
        return en && (dest != 0);
    endfunction

    function automatic logic [W-1:0] m_read(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (m_valid() && idx == dest) return m_wb();
        return mregs[idx];
    endfunction

    task automatic drive(input logic e, input logic m, input logic [W-1:0] md,
                         input logic [W-1:0] ad, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        en = e; m2r = m; mem_d = md; alu_d = ad; dest = d; r1 = a; r2 = b;
        #1;
    endtask

    // Advance one edge and apply the commit rule to the model.
    task automatic tick();
        logic          v;
        logic [W-1:0]  w;
        v = m_valid() && reset;
        w = m_wb();
        @(posedge clk);
        if (v) begin
            mregs[dest] = w;
            mcount = (mcount + 1) % (1 << CW);
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcount = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
        model_clear();
        tick();
        tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, '0, '0, 5'd0, 5'(i), 5'(31 - i));
            n_cmp++;
            if (rd1 !== '0 || rd2 !== '0) begin
                n_bad++;
                $display("FAIL reset_read idx=%0d got %h/%h want 0", i, rd1, rd2);
            end
        end
        n_cmp++;
        if (cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_count got %0d want 0", cnt);
        end
    endtask

    task automatic test_alu_wb();
        drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h0000_1234, 5'd5, 5'd1, 5'd2);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd0);
        n_cmp++;
        if (rd1 !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL alu_readback got %h want 00001234", rd1);
        end
        n_cmp++;
        if (cnt !== CW'(1)) begin
            n_bad++;
            $display("FAIL alu_count got %0d want 1", cnt);
        end
    endtask

    task automatic test_mem_bypass();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9, 5'd9, 5'd9);
        n_cmp++;
        if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF || wb !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL mem_bypass got %h/%h wb %h want deadbeef", rd1, rd2, wb);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd9, 5'd9);
        n_cmp++;
        if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL mem_commit got %h/%h want deadbeef", rd1, rd2);
        end
    endtask

    task automatic test_reg0();
        int c0;
        c0 = mcount;
        drive(1'b1, 1'b0, '0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        n_cmp++;
        if (rd1 !== '0 || valid !== 1'b0 || wb !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL reg0_pre got rd %h valid %b wb %h want 0 0 ffffffff", rd1, valid, wb);
        end
        tick();
        n_cmp++;
        if (rd1 !== '0 || cnt !== CW'(c0)) begin
            n_bad++;
            $display("FAIL reg0_post got rd %h cnt %0d want 0 %0d", rd1, cnt, c0);
        end
    endtask

    task automatic test_disabled();
        int c0;
        drive(1'b1, 1'b0, '0, 32'h0000_00AA, 5'd7, 5'd0, 5'd0);
        tick();
        c0 = mcount;
        drive(1'b0, 1'b0, '0, 32'h0000_0055, 5'd7, 5'd0, 5'd7);
        n_cmp++;
        if (rd2 !== 32'h0000_00AA || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL disabled_pre got %h valid %b want 000000aa 0", rd2, valid);
        end
        tick();
        n_cmp++;
        if (rd2 !== 32'h0000_00AA || cnt !== CW'(c0)) begin
            n_bad++;
            $display("FAIL disabled_post got %h cnt %0d want 000000aa %0d", rd2, cnt, c0);
        end
    endtask

    task automatic test_random();
        logic [4:0] d;
        logic [4:0] a;
        logic [4:0] b;
        for (int k = 0; k < 300; k++) begin
            d = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, d, a, b);
            n_cmp++;
            if (wb !== m_wb() || valid !== m_valid() ||
                rd1 !== m_read(a) || rd2 !== m_read(b)) begin
                n_bad++;
                $display("FAIL random k=%0d got wb %h v %b rd %h/%h want %h %b %h/%h",
                         k, wb, valid, rd1, rd2, m_wb(), m_valid(), m_read(a), m_read(b));
            end
            tick();
            n_cmp++;
            if (cnt !== CW'(mcount)) begin
                n_bad++;
                $display("FAIL random_count k=%0d got %0d want %0d", k, cnt, mcount);
            end
        end
    endtask

    task automatic test_wrap_async_reset();
        int  wraps;
        int  prev;
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            prev = mcount;
            drive(1'b1, 1'b0, '0, $urandom, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
            tick();
            if (prev == 15) wraps++;
            n_cmp++;
            if (cnt !== CW'((prev + 1) % 16)) begin
                n_bad++;
                $display("FAIL wrap_count k=%0d got %0d want %0d", k, cnt, (prev + 1) % 16);
            end
        end
        n_cmp++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL wrap_seen got %0d wraps want 1", wraps);
        end
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd1, 5'd2);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (cnt !== '0) begin
            n_bad++;
            $display("FAIL async_count got %0d want 0", cnt);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, '0, '0, 5'd0, 5'(i), 5'(32 - i));
            n_cmp++;
            if (rd1 !== '0 || rd2 !== '0) begin
                n_bad++;
                $display("FAIL async_regs idx=%0d got %h/%h want 0", i, rd1, rd2);
            end
        end
        drive(1'b1, 1'b0, '0, 32'h1357_9BDF, 5'd3, 5'd4, 5'd3);
        n_cmp++;
        if (rd2 !== 32'h1357_9BDF) begin
            n_bad++;
            $display("FAIL reset_bypass got %h want 13579bdf", rd2);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd3, 5'd3);
        n_cmp++;
        if (rd1 !== '0 || cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_nocommit got %h cnt %0d want 0 0", rd1, cnt);
        end
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h0BAD_F00D, '0, 5'd3, 5'd3, 5'd0);
        tick();
        n_cmp++;
        if (rd1 !== 32'h0BAD_F00D || cnt !== CW'(1)) begin
            n_bad++;
            $display("FAIL first_edge got %h cnt %0d want 0badf00d 1", rd1, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu_wb();
        test_mem_bypass();
        test_reg0();
        test_disabled();
        test_random();
        test_wrap_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
